level_bg_gen: RTL and testbench
===============================

Name: level_bg_gen

Overview:
- Parametrised background renderer for game levels: border lines, ground band, sky, and N animated circular clouds drifting right and wrapping around the screen.
- Sits in the VGA chain directly after the timing generator, ahead of sprite/house overlay blocks.
- Uses a fixed-latency pipeline for the circle-distance arithmetic, with all timing signals delay-matched to the colour output.

Parameters:
- N_CLOUDS, 4, number of clouds (1..8).
- CLOUD_R, 40, cloud radius in pixels (1..127).
- CLOUD_Y0, 100, centre row of even-indexed clouds.
- CLOUD_DY, 60, extra row offset added for odd-indexed clouds.
- GROUND_Y, 500, first ground row is GROUND_Y+1.
- SPEED_DIV, 2, frames per one-pixel cloud step (>=1).

Ports:
- clk  in  1  pixel clock.
- rst  in  1  synchronous reset, active-high.
- pause  in  1  freezes cloud motion while high.
- vga_in  vga_if.in  -  vcount[10:0], hcount[10:0], vsync, hsync, vblnk, hblnk, rgb[11:0] (incoming rgb ignored).
- vga_out  vga_if.out  -  same fields, delayed 3 cycles, rgb generated here.

Behaviour:
- Reset (rst, synchronous, active-high; clock clk): all vga_out fields 0, all pipeline registers 0, frame_cnt 0, cloud i x-centre = i*HOR_PIXELS/N_CLOUDS, y-centre = CLOUD_Y0 + (i odd ? CLOUD_DY : 0).
- Latency: exactly 3 clk from vga_in to vga_out for every field. After reset release, outputs follow the pipeline, so the first 3 cycles out are 0.
- Stage 1: dx_i = hcount - cx_i, dy_i = vcount - cy_i, signed 12-bit. Stage 2: dx_i^2, dy_i^2, unsigned 22-bit. Stage 3: hit_i = (dx_i^2 + dy_i^2 <= CLOUD_R^2), 23-bit sum, compared in the same cycle as final colour selection. Timing/blank/counts are delayed alongside each stage.
- Colour priority, evaluated on the stage-3 aligned signals:
  - vblnk|hblnk -> 000.
  - vcount==0 -> FF0.
  - vcount==VER_PIXELS-1 -> F00.
  - hcount==0 -> 0F0.
  - hcount==HOR_PIXELS-1 -> 00F.
  - vcount>GROUND_Y -> 0F0.
  - any hit_i -> FFF.
  - else -> 00F.
- Frame tick: one-cycle pulse on the vblnk rising edge (previous-vblnk register), measured at vga_in.
- Motion:
  - On a tick with pause=0: if frame_cnt==SPEED_DIV-1, then frame_cnt<=0 and every cx_i advances by 1 (odd i: by 2); otherwise frame_cnt increments.
  - On a tick with pause=1: frame_cnt and positions hold.
- Wrap: cx_i is signed 12-bit. If the next value would be > HOR_PIXELS-1+CLOUD_R, load -CLOUD_R instead, so the cloud re-enters from the left edge fully hidden.
- Positions change only at a tick, so they are always stable during active video; no tearing.
- Reset mid-frame: immediate return to reset state; rendering resumes correctly at the next pixel after the 3-cycle refill.
- pause asserted in the same cycle as a tick: pause wins and nothing moves.

Decomposition:
- New package level_pkg holds:
  - Colour constants: C_BLACK, C_YELLOW, C_RED, C_GREEN, C_BLUE, C_WHITE, C_SKY.
  - typedef cloud_pos_t: a struct of signed [11:0] x, unsigned [10:0] y.
  - Function initial_cloud(i), returning the reset position.
- HOR_PIXELS and VER_PIXELS stay in vga_pkg.
- One sub-module, circle_hit_pipe: 3-stage pipeline taking one centre, hcount/vcount and radius, and producing hit. Instantiated N_CLOUDS times in a generate loop.
- Motion registers and colour mux stay in level_bg_gen.

Test Plan:
- Latency: drive hcount=5, vcount=5, hblnk=vblnk=0 for one cycle. vga_out.hcount==5 exactly 3 cycles later; hsync/vsync/blnk are likewise shifted by 3.
- Colour regions, defaults after reset:
  - Pixel (400,300) -> 00F.
  - (400,510) -> 0F0.
  - (0,0) -> FF0.
  - (400,599) -> F00.
  - Any pixel with hblnk=1 -> 000.
- Cloud hit: cloud 1 resets at x=200,y=160. Pixel (200,160) -> FFF; (240,160) -> FFF (d^2=1600=R^2); (241,160) -> 00F.
- Motion: after 2 vblnk rising edges (SPEED_DIV=2), cloud 0 centre moves from 0 to 1 and cloud 1 from 200 to 202. Pixel (241,160) is now FFF.
- Wrap and pause:
  - Force cloud 0 to x=839 (HOR_PIXELS=800, R=40); the next step loads -40 and pixel (0..) shows no cloud.
  - With pause=1 over 10 frames, all positions are unchanged.
- Reset mid-frame: assert rst at hcount=300 for 1 cycle. vga_out is all 0 for 3 cycles, the cloud positions equal their reset values, and correct colours resume afterwards.

Source files
------------

// File: rtl/level_pkg.sv
// Types, colours and helpers for the level background renderer.
//   cloud_pos_t   : cloud centre, signed x so a cloud can sit off the left edge
//   vga_timing_t  : the timing/count fields of the VGA bus, without colour
//   initial_cloud : reset position of cloud i
package level_pkg;

    import vga_pkg::*;

    localparam logic [11:0] C_BLACK  = 12'h000;
    localparam logic [11:0] C_YELLOW = 12'hFF0;
    localparam logic [11:0] C_RED    = 12'hF00;
    localparam logic [11:0] C_GREEN  = 12'h0F0;
    localparam logic [11:0] C_BLUE   = 12'h00F;
    localparam logic [11:0] C_WHITE  = 12'hFFF;
    localparam logic [11:0] C_SKY    = 12'h00F;

    typedef struct packed {
        logic signed [11:0] x;
        logic        [10:0] y;
    } cloud_pos_t;

    typedef struct packed {
        logic [10:0] vcount;
        logic [10:0] hcount;
        logic        vsync;
        logic        hsync;
        logic        vblnk;
        logic        hblnk;
    } vga_timing_t;

    // Clouds start evenly spread across the screen; odd clouds sit lower.
    function automatic cloud_pos_t initial_cloud(input int i, input int nClouds,
                                                 input int y0, input int dy);
        cloud_pos_t p;
        p.x = 12'(i * HOR_PIXELS / nClouds);
        p.y = 11'(y0 + (((i % 2) == 1) ? dy : 0));
        return p;
    endfunction

endpackage

// File: rtl/vga_pkg.sv
// Shared VGA geometry for the display chain.
// Only the visible-area size is needed by the blocks in this slice.
package vga_pkg;

    localparam int HOR_PIXELS = 800;
    localparam int VER_PIXELS = 600;

endpackage

// File: rtl/vga_if.sv
// VGA bus between the stages of the display chain.
//   in  : consumer view (everything is an input)
//   out : producer view (everything is an output)
interface vga_if;

    logic [10:0] vcount;
    logic [10:0] hcount;
    logic        vsync;
    logic        hsync;
    logic        vblnk;
    logic        hblnk;
    logic [11:0] rgb;

    modport in  (input  vcount, hcount, vsync, hsync, vblnk, hblnk, rgb);
    modport out (output vcount, hcount, vsync, hsync, vblnk, hblnk, rgb);

endinterface

// File: rtl/level_bg_gen_circle_hit_pipe.sv
// Circle membership test for one cloud, pipelined for the pixel clock.
//   clk, rst   : pixel clock, synchronous active-high reset
//   center_i   : cloud centre (sampled together with the pixel coordinates)
//   hcount_i   : pixel column
//   vcount_i   : pixel row
//   radius_i   : circle radius in pixels
//   hit_o      : pixel lies inside or on the circle
// Stages 1 and 2 are registered here; hit_o is the combinational stage-3
// compare, which the parent registers together with the final colour.
module circle_hit_pipe
    import level_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  cloud_pos_t  center_i,
    input  logic [10:0] hcount_i,
    input  logic [10:0] vcount_i,
    input  logic [6:0]  radius_i,
    output logic        hit_o
);

    logic signed [11:0] dx_d, dy_d, dx_q, dy_q;
    logic signed [23:0] dxExt, dyExt, dxProd, dyProd;
    logic        [21:0] dx2_q, dy2_q;
    logic        [22:0] distSq;
    logic        [13:0] rSq;

    assign dx_d = $signed({1'b0, hcount_i}) - center_i.x;
    assign dy_d = $signed({1'b0, vcount_i}) - $signed({1'b0, center_i.y});

    // Sign-extend before squaring so the product is taken at full width.
    assign dxExt  = 24'(dx_q);
    assign dyExt  = 24'(dy_q);
    assign dxProd = dxExt * dxExt;
    assign dyProd = dyExt * dyExt;

    always_ff @(posedge clk) begin
        if (rst) begin
            dx_q  <= '0;
            dy_q  <= '0;
            dx2_q <= '0;
            dy2_q <= '0;
        end else begin
            dx_q  <= dx_d;
            dy_q  <= dy_d;
            dx2_q <= dxProd[21:0];
            dy2_q <= dyProd[21:0];
        end
    end

    assign distSq = {1'b0, dx2_q} + {1'b0, dy2_q};
    assign rSq    = {7'b0, radius_i} * {7'b0, radius_i};
    assign hit_o  = (distSq <= {9'b0, rSq});

endmodule

// File: rtl/level_bg_gen.sv
// Level background renderer: borders, ground band, sky and drifting clouds.
//   clk, rst : pixel clock, synchronous active-high reset
//   pause    : freezes cloud motion while high
//   vga_in   : timing from the VGA timing generator (incoming rgb unused)
//   vga_out  : same timing delayed by 3 clocks, with the generated colour
module level_bg_gen
    import vga_pkg::*;
    import level_pkg::*;
#(
    parameter int N_CLOUDS  = 4,
    parameter int CLOUD_R   = 40,
    parameter int CLOUD_Y0  = 100,
    parameter int CLOUD_DY  = 60,
    parameter int GROUND_Y  = 500,
    parameter int SPEED_DIV = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic pause,
    vga_if.in    vga_in,
    vga_if.out   vga_out
);

    localparam int FC_W = (SPEED_DIV > 1) ? $clog2(SPEED_DIV) : 1;
    localparam logic [FC_W-1:0]   FC_LAST = FC_W'(SPEED_DIV - 1);
    localparam logic signed [11:0] X_MAX  = 12'(HOR_PIXELS - 1 + CLOUD_R);
    localparam logic signed [11:0] X_WRAP = 12'(-CLOUD_R);

    vga_timing_t        inTiming, s1_q, s2_q;
    logic               vld1_q, vld2_q;
    logic [N_CLOUDS-1:0] hit;
    logic [11:0]        colour;

    cloud_pos_t         cloud_q [N_CLOUDS];
    cloud_pos_t         cloud_d [N_CLOUDS];
    logic [FC_W-1:0]    frameCnt_q, frameCnt_d;
    logic               vblnkPrev_q;
    logic               tick;
    logic signed [11:0] nextX;

    assign inTiming = '{vcount: vga_in.vcount, hcount: vga_in.hcount,
                        vsync:  vga_in.vsync,  hsync:  vga_in.hsync,
                        vblnk:  vga_in.vblnk,  hblnk:  vga_in.hblnk};

    // Timing delay line matching the two registered stages of the hit pipes.
    // The valid bits keep the colour at zero while the pipe refills after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q   <= '0;
            s2_q   <= '0;
            vld1_q <= 1'b0;
            vld2_q <= 1'b0;
        end else begin
            s1_q   <= inTiming;
            s2_q   <= s1_q;
            vld1_q <= 1'b1;
            vld2_q <= vld1_q;
        end
    end

    for (genvar g = 0; g < N_CLOUDS; g++) begin : g_cloud
        circle_hit_pipe u_hit (
            .clk      (clk),
            .rst      (rst),
            .center_i (cloud_q[g]),
            .hcount_i (vga_in.hcount),
            .vcount_i (vga_in.vcount),
            .radius_i (7'(CLOUD_R)),
            .hit_o    (hit[g])
        );
    end

    // Frame tick on the vblnk rising edge as seen at the input, so clouds only
    // move during blanking and never mid-picture.
    assign tick = vga_in.vblnk & ~vblnkPrev_q;

    always_comb begin
        frameCnt_d = frameCnt_q;
        cloud_d    = cloud_q;
        nextX      = '0;
        if (tick && !pause) begin
            if (frameCnt_q == FC_LAST) begin
                frameCnt_d = '0;
                for (int i = 0; i < N_CLOUDS; i++) begin
                    nextX = cloud_q[i].x + (((i % 2) == 1) ? 12'sd2 : 12'sd1);
                    // Re-enter from the left fully hidden once past the right edge.
                    cloud_d[i].x = (nextX > X_MAX) ? X_WRAP : nextX;
                end
            end else begin
                frameCnt_d = frameCnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            frameCnt_q  <= '0;
            vblnkPrev_q <= 1'b0;
            for (int i = 0; i < N_CLOUDS; i++) begin
                cloud_q[i] <= initial_cloud(i, N_CLOUDS, CLOUD_Y0, CLOUD_DY);
            end
        end else begin
            frameCnt_q  <= frameCnt_d;
            vblnkPrev_q <= vga_in.vblnk;
            cloud_q     <= cloud_d;
        end
    end

    // Colour priority: blanking, then borders, then ground, then clouds, then sky.
    always_comb begin
        colour = C_SKY;
        if (s2_q.vblnk || s2_q.hblnk)                   colour = C_BLACK;
        else if (s2_q.vcount == 11'd0)                  colour = C_YELLOW;
        else if (s2_q.vcount == 11'(VER_PIXELS - 1))    colour = C_RED;
        else if (s2_q.hcount == 11'd0)                  colour = C_GREEN;
        else if (s2_q.hcount == 11'(HOR_PIXELS - 1))    colour = C_BLUE;
        else if (s2_q.vcount > 11'(GROUND_Y))           colour = C_GREEN;
        else if (|hit)                                  colour = C_WHITE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vga_out.vcount <= '0;
            vga_out.hcount <= '0;
            vga_out.vsync  <= 1'b0;
            vga_out.hsync  <= 1'b0;
            vga_out.vblnk  <= 1'b0;
            vga_out.hblnk  <= 1'b0;
            vga_out.rgb    <= '0;
        end else begin
            vga_out.vcount <= s2_q.vcount;
            vga_out.hcount <= s2_q.hcount;
            vga_out.vsync  <= s2_q.vsync;
            vga_out.hsync  <= s2_q.hsync;
            vga_out.vblnk  <= s2_q.vblnk;
            vga_out.hblnk  <= s2_q.hblnk;
            vga_out.rgb    <= vld2_q ? colour : C_BLACK;
        end
    end

endmodule

// File: tb/tb_level_bg_gen.sv
// Scoreboard bench for level_bg_gen: the driver pushes the expected output of
// every driven pixel, tagged with the cycle it must appear on; the monitor
// pops and compares on the falling edge.
module tb_level_bg_gen;

    import vga_pkg::*;

    localparam int N  = 4;
    localparam int R  = 40;
    localparam int Y0 = 100;
    localparam int DY = 60;
    localparam int GY = 500;
    localparam int SD = 2;

    typedef struct {
        int          due;
        logic [10:0] v;
        logic [10:0] h;
        logic        vs;
        logic        hs;
        logic        vb;
        logic        hb;
        logic [11:0] rgb;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic pause;
    int   cycleCount = 0;
    int   errors = 0;
    int   checks = 0;
    exp_t sb[$];

    int   cx [N];
    int   cy [N];
    int   frameCnt;
    logic prevVb;

    vga_if vin();
    vga_if vout();

    level_bg_gen #(
        .N_CLOUDS(N), .CLOUD_R(R), .CLOUD_Y0(Y0), .CLOUD_DY(DY),
        .GROUND_Y(GY), .SPEED_DIV(SD)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .pause   (pause),
        .vga_in  (vin),
        .vga_out (vout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycleCount <= cycleCount + 1;

    // Reference model: clouds as integer centres, colour from the region rules.
    function automatic void modelReset();
        for (int i = 0; i < N; i++) begin
            cx[i] = i * HOR_PIXELS / N;
            cy[i] = Y0 + ((i % 2 == 1) ? DY : 0);
        end
        frameCnt = 0;
        prevVb   = 1'b0;
    endfunction

    function automatic logic [11:0] refColour(input int h, input int v,
                                              input logic hb, input logic vb);
        bit inCloud = 0;
        for (int i = 0; i < N; i++)
            if ((h - cx[i]) * (h - cx[i]) + (v - cy[i]) * (v - cy[i]) <= R * R)
                inCloud = 1;
        if (hb || vb)                return 12'h000;
        if (v == 0)                  return 12'hFF0;
        if (v == VER_PIXELS - 1)     return 12'hF00;
        if (h == 0)                  return 12'h0F0;
        if (h == HOR_PIXELS - 1)     return 12'h00F;
        if (v > GY)                  return 12'h0F0;
        if (inCloud)                 return 12'hFFF;
        return 12'h00F;
    endfunction

    function automatic void modelFrame(input logic vb, input logic ps);
        if (vb && !prevVb && !ps) begin
            if (frameCnt == SD - 1) begin
                frameCnt = 0;
                for (int i = 0; i < N; i++) begin
                    cx[i] = cx[i] + ((i % 2 == 1) ? 2 : 1);
                    if (cx[i] > HOR_PIXELS - 1 + R) cx[i] = -R;
                end
            end else begin
                frameCnt = frameCnt + 1;
            end
        end
        prevVb = vb;
    endfunction

    task automatic applyStimulus(input int h, input int v, input logic hs, input logic vs,
                                 input logic hb, input logic vb, input logic ps, input logic r);
        exp_t e;
        @(posedge clk);
        #1;
        vin.hcount = 11'(h);
        vin.vcount = 11'(v);
        vin.hsync  = hs;
        vin.vsync  = vs;
        vin.hblnk  = hb;
        vin.vblnk  = vb;
        vin.rgb    = 12'($urandom);
        pause      = ps;
        rst        = r;
        e.due = cycleCount + 3;
        if (r) begin
            // Reset flushes everything still in flight.
            foreach (sb[k]) begin
                if (sb[k].due > cycleCount) begin
                    sb[k].v = '0; sb[k].h = '0; sb[k].vs = 0; sb[k].hs = 0;
                    sb[k].vb = 0; sb[k].hb = 0; sb[k].rgb = '0;
                end
            end
            e.v = '0; e.h = '0; e.vs = 0; e.hs = 0; e.vb = 0; e.hb = 0; e.rgb = '0;
            modelReset();
        end else begin
            e.v = 11'(v); e.h = 11'(h); e.vs = vs; e.hs = hs; e.vb = vb; e.hb = hb;
            e.rgb = refColour(h, v, hb, vb);
            modelFrame(vb, ps);
        end
        sb.push_back(e);
    endtask

    task automatic pixel(input int h, input int v);
        applyStimulus(h, v, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic frameEdge(input logic ps);
        applyStimulus(400, 300, 1'b0, 1'b0, 1'b0, 1'b0, ps, 1'b0);
        applyStimulus(0, 601, 1'b0, 1'b1, 1'b0, 1'b1, ps, 1'b0);
    endtask

    task automatic nearCloud(output int h, output int v);
        int i;
        i = int'($urandom_range(0, N - 1));
        h = cx[i] + int'($urandom_range(0, 2 * R + 10)) - R - 5;
        v = cy[i] + int'($urandom_range(0, 2 * R + 10)) - R - 5;
        if (h < 0) h = 0;
        if (v < 0) v = 0;
    endtask

    task automatic checkOutput(input exp_t e);
        logic [39:0] act, req;
        act = {vout.vcount, vout.hcount, vout.vsync, vout.hsync, vout.vblnk, vout.hblnk, vout.rgb};
        req = {e.v, e.h, e.vs, e.hs, e.vb, e.hb, e.rgb};
        checks++;
        if (e.due != cycleCount || act !== req) begin
            errors++;
            $display("[TB] FAIL out@cycle%0d: got v=%0d h=%0d vs=%b hs=%b vb=%b hb=%b rgb=%h, want v=%0d h=%0d vs=%b hs=%b vb=%b hb=%b rgb=%h (due %0d)",
                     cycleCount, vout.vcount, vout.hcount, vout.vsync, vout.hsync, vout.vblnk,
                     vout.hblnk, vout.rgb, e.v, e.h, e.vs, e.hs, e.vb, e.hb, e.rgb, e.due);
        end
    endtask

    // Monitor: compare every expected entry on the cycle it falls due.
    initial begin
        forever begin
            @(negedge clk);
            while (sb.size() > 0 && sb[0].due <= cycleCount) checkOutput(sb.pop_front());
        end
    end

    initial begin
        int h, v, guard;
        rst = 1'b1; pause = 1'b0;
        vin.hcount = '0; vin.vcount = '0; vin.hsync = 0; vin.vsync = 0;
        vin.hblnk = 0; vin.vblnk = 0; vin.rgb = '0;
        modelReset();
        repeat (3) applyStimulus(0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        // Latency with distinctive timing bits
        applyStimulus(5, 5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(6, 5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(7, 5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);

        // Region colours and reset cloud positions
        pixel(400, 300); pixel(400, 510); pixel(0, 0); pixel(400, 599);
        pixel(0, 300); pixel(799, 300); pixel(400, 501); pixel(400, 500);
        applyStimulus(400, 300, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        pixel(200, 160); pixel(240, 160); pixel(241, 160); pixel(0, 100); pixel(40, 100);

        // Two frame ticks move the clouds one step
        frameEdge(1'b0); frameEdge(1'b0);
        pixel(241, 160); pixel(242, 160); pixel(243, 160); pixel(41, 100); pixel(42, 100);

        // Randomised pixels, blanking, pause and frame edges
        for (int k = 0; k < 400; k++) begin
            nearCloud(h, v);
            applyStimulus(h, v, 1'($urandom), 1'($urandom), ($urandom % 8) == 0,
                          ($urandom % 6) == 0, ($urandom % 4) == 0, 1'b0);
        end

        // Run cloud 0 up to the right edge, then through the wrap
        guard = 0;
        while (cx[0] != HOR_PIXELS - 1 + R && guard < 3000) begin frameEdge(1'b0); guard++; end
        for (int k = 0; k < 20; k++) begin nearCloud(h, v); pixel(h, v); end
        guard = 0;
        while (cx[0] != -R && guard < 10) begin frameEdge(1'b0); guard++; end
        pixel(1, 100); pixel(2, 100); pixel(1, 90); pixel(760, 100); pixel(798, 100);

        // Ten paused frames must not move anything
        repeat (10) frameEdge(1'b1);
        for (int i = 0; i < N; i++) begin
            if (cx[i] + R >= 0) pixel(cx[i] + R, cy[i]);
            if (cx[i] + R + 1 >= 0) pixel(cx[i] + R + 1, cy[i]);
        end
        for (int k = 0; k < 20; k++) begin nearCloud(h, v); pixel(h, v); end

        // Reset in the middle of a line
        for (int hh = 295; hh < 300; hh++) pixel(hh, 160);
        applyStimulus(300, 160, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int hh = 301; hh < 306; hh++) pixel(hh, 160);
        pixel(200, 160); pixel(240, 160); pixel(241, 160); pixel(600, 160);
        pixel(640, 160); pixel(641, 160); pixel(400, 140); pixel(400, 141);

        // Drain the scoreboard within a bounded number of cycles
        guard = 0;
        while (sb.size() > 0 && guard < 10) begin @(posedge clk); guard++; end
        @(negedge clk); #1;
        if (sb.size() > 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL drain: %0d entries left, want 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
